// File: rtl/aes_pkg.sv
// AES-128 tables, GF(2^8) helpers, round-level transforms and FSM state type.
package aes_pkg;

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

  localparam logic [1:10][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] prev, input logic [7:0] rcon);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word(rot_word(prev[31:0])) ^ {rcon, 24'h0};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the block sits at [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns unless last.
// Latency: combinational. Backpressure: none.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] next_state
);

  logic [127:0] keyed;

  assign keyed      = inv_sub_bytes(inv_shift_rows(state)) ^ round_key;
  assign next_state = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 decryptor, one round per clock; AES_DEC_KEYCACHE_EN reuses the last expanded key.
// Latency: done 21 cycles after start accept (11 on a key-cache hit).
// Backpressure: done/plaintext held until unpack_ready; start accepted only while ready.
module aes128_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  input  logic         start,
  output logic         ready,
  output logic [127:0] plaintext,
  output logic         done,
  input  logic         unpack_ready
);

  state_t       fsm;
  logic [3:0]   kcnt;
  logic [3:0]   rnd;
  logic [127:0] ct_q;
  logic [127:0] blk;
  logic [127:0] round_keys [0:10];
  logic [127:0] rk_next;
  logic [127:0] rk_cur;
  logic [127:0] blk_next;
`ifdef AES_DEC_KEYCACHE_EN
  logic         cache_valid;
`endif

  always_comb begin
    rk_next = next_round_key(round_keys[kcnt - 4'd1], RCON[kcnt]);
    rk_cur  = round_keys[rnd - 4'd1];
  end

  aes_inv_round u_round (
    .state      (blk),
    .round_key  (rk_cur),
    .last       (rnd == 4'd1),
    .next_state (blk_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm       <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      plaintext <= '0;
      rnd       <= '0;
      kcnt      <= '0;
`ifdef AES_DEC_KEYCACHE_EN
      cache_valid <= 1'b0;
`endif
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            ct_q  <= ciphertext;
            ready <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
            // round_keys[0] doubles as the cached key once a full expansion has finished
            if (cache_valid && key == round_keys[0]) begin
              fsm <= INIT;
            end else begin
              round_keys[0] <= key;
              kcnt          <= 4'd1;
              cache_valid   <= 1'b0;
              fsm           <= KEYEXP;
            end
`else
            round_keys[0] <= key;
            kcnt          <= 4'd1;
            fsm           <= KEYEXP;
`endif
          end
        end
        KEYEXP: begin
          round_keys[kcnt] <= rk_next;
          kcnt             <= kcnt + 4'd1;
          if (kcnt == 4'd10) begin
            fsm <= INIT;
`ifdef AES_DEC_KEYCACHE_EN
            cache_valid <= 1'b1;
`endif
          end
        end
        INIT: begin
          blk <= ct_q ^ round_keys[10];
          rnd <= 4'd10;
          fsm <= ROUND;
        end
        ROUND: begin
          blk <= blk_next;
          rnd <= rnd - 4'd1;
          if (rnd == 4'd1) begin
            plaintext <= blk_next;
            done      <= 1'b1;
            fsm       <= DONE;
          end
        end
        DONE: begin
          if (unpack_ready) begin
            done  <= 1'b0;
            ready <= 1'b1;
            fsm   <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt.sv
// Directed bench for aes128_decrypt with a byte-level AES reference model and per-cycle monitor.
module tb_aes128_decrypt;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] LK1 = 128'h3AF291850C4D7E6B1A9F5238D4E07C29;
  localparam logic [127:0] LK2 = 128'hE519B04A7CD28F6391E4A50B2D873CF6;
  localparam logic [127:0] LK3 = 128'h84C15A2B9E7D3F061852B749D0A3E52C;
`ifdef AES_DEC_KEYCACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif

  logic         clk = 1'b0;
  logic         reset, start, ready, done, unpack_ready;
  logic [127:0] key, ciphertext, plaintext;
  logic [127:0] lk, lct;
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  int           n_checks = 0;
  int           n_pass   = 0;

  aes128_decrypt dut (
    .clk          (clk),
    .reset        (reset),
    .key          (key),
    .ciphertext   (ciphertext),
    .start        (start),
    .ready        (ready),
    .plaintext    (plaintext),
    .done         (done),
    .unpack_ready (unpack_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul_m(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box from the multiplicative inverse plus the affine map.
  function automatic void build_tables();
    logic [7:0] inv, s;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul_m(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      s = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t  = t ^ {rc, 24'h0};
        rc = gmul_m(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] sub_m(input logic [127:0] x, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isb[x[127-8*i -: 8]] : sb[x[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_m(input logic [127:0] x, input int dir);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+dir*r+8)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_m(input logic [127:0] x, input bit inv);
    logic [127:0] o;
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul_m(cf[(j-r+4)%4], x[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [127:0] x;
    x = pt ^ round_key(k, 0);
    for (int r = 1; r <= 10; r++) begin
      x = shift_m(sub_m(x, 1'b0), 1);
      if (r < 10) x = mix_m(x, 1'b0);
      x = x ^ round_key(k, r);
    end
    return x;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] ct);
    logic [127:0] x;
    x = ct ^ round_key(k, 10);
    for (int r = 9; r >= 0; r--) begin
      x = sub_m(shift_m(x, -1), 1'b1) ^ round_key(k, r);
      if (r > 0) x = mix_m(x, 1'b1);
    end
    return x;
  endfunction

  // ---------------- cycle monitor ----------------
  initial begin
    bit           live, m_ready, m_done, c_valid, hit;
    int           m_cnt;
    logic [127:0] m_pt, m_next, c_key;
    live = 0; m_ready = 1; m_done = 0; c_valid = 0; m_cnt = 0;
    m_pt = '0; m_next = '0; c_key = '0;
    forever begin
      @(posedge clk);
      if (reset === 1'b0) begin
        live = 1; m_ready = 1; m_done = 0; m_pt = '0; m_cnt = 0; c_valid = 0;
      end else if (live) begin
        if (m_ready && start) begin
          m_ready = 0;
          m_next  = model_dec(key, ciphertext);
`ifdef AES_DEC_KEYCACHE_EN
          hit = c_valid && (key == c_key);
`else
          hit = 0;
`endif
          m_cnt   = hit ? 11 : 21;
          c_key   = key;
          c_valid = 1;
        end else if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin m_done = 1; m_pt = m_next; end
        end else if (m_done && unpack_ready) begin
          m_done = 0; m_ready = 1;
        end
      end
      @(negedge clk);
      if (live) begin
        check("mon_ready", 128'(ready), 128'(m_ready));
        check("mon_done", 128'(done), 128'(m_done));
        check("mon_plaintext", plaintext, m_pt);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input string name, input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] exp_pt, input int exp_lat);
    int n;
    check({name, "_ready_idle"}, 128'(ready), 128'd1);
    key = k; ciphertext = ct; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; key = ~k; ciphertext = ~ct;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check({name, "_latency"}, 128'(n), 128'(exp_lat));
    check({name, "_done"}, 128'(done), 128'd1);
    check({name, "_pt"}, plaintext, exp_pt);
  endtask

  task automatic release_result(input string name);
    unpack_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    unpack_ready = 1'b0;
    check({name, "_ready_after"}, 128'(ready), 128'd1);
    check({name, "_done_clear"}, 128'(done), 128'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; unpack_ready = 1'b0; key = '0; ciphertext = '0;
    build_tables();
    check("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    check("model_c1_enc", model_enc(K1, P1), C1);
    check("model_c1_dec", model_dec(K1, C1), P1);
    check("model_b_rk10", round_key(KB, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // 1: reset values
    repeat (10) @(negedge clk);
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_done", 128'(done), 128'd0);
    check("rst_pt", plaintext, 128'd0);
    reset = 1'b1;
    unpack_ready = 1'b1;            // ignored outside DONE
    @(negedge clk);
    unpack_ready = 1'b0;
    @(negedge clk);
    check("idle_ready", 128'(ready), 128'd1);

    // 2, 3: FIPS vectors
    run_op("fips_c1", K1, C1, P1, 21);
    release_result("fips_c1");
    run_op("fips_b", KB, CB, PB, 21);
    release_result("fips_b");

    // 4: loopback through the encryption model
    lk  = ~((LK1 ^ LK2) | LK3);
    lct = model_enc(lk, P1);
    run_op("loop", lk, lct, P1, 21);
    release_result("loop");

    // 5: backpressure with an ignored start
    run_op("bp", KB, CB, PB, 21);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin start = 1'b1; key = K1; ciphertext = C1; end
      if (i == 11) start = 1'b0;
      @(posedge clk); @(negedge clk);
      check("bp_done_hold", 128'(done), 128'd1);
      check("bp_pt_hold", plaintext, PB);
    end
    release_result("bp");
    repeat (3) @(negedge clk);
    check("bp_no_queue", 128'(done), 128'd0);

    // 6: abort during round 5, then rerun and repeat
    key = K1; ciphertext = C1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (16) begin @(posedge clk); @(negedge clk); end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_ready", 128'(ready), 128'd1);
    check("abort_done", 128'(done), 128'd0);
    check("abort_pt", plaintext, 128'd0);
    reset = 1'b1;
    @(negedge clk);
    run_op("rerun", K1, C1, P1, 21);
    release_result("rerun");
    run_op("repeat", K1, C1, P1, HIT_LAT);
    release_result("repeat");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
